// File: rtl/starfield_speed_ctl.sv
// Starfield speed register driver: ramps or jumps toward a CPU-set target,
// issuing writes to the starfield only at the start of vertical blanking.
module starfield_speed_ctl #(
  parameter int unsigned STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_data,
  output logic       sf_write,
  output logic [7:0] sf_data,
  output logic [3:0] cur_speed,
  output logic       busy
);

  localparam int unsigned SPEED_W = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    JUMP = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SPEED_W-1:0] target, target_nxt;
  logic               imm_pend, imm_pend_nxt;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic [SPEED_W-1:0] cur_speed_nxt;
  logic               sf_write_nxt;
  logic [7:0]         sf_data_nxt;
  logic               busy_nxt;
  logic               vb_q, vb_qq, vb_edge;

  // Vblank history; the registered rising edge is what the FSM acts on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_q    <= 1'b0;
      vb_qq   <= 1'b0;
      vb_edge <= 1'b0;
    end else begin
      vb_q    <= vblank;
      vb_qq   <= vb_q;
      vb_edge <= vb_q & ~vb_qq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      imm_pend  <= 1'b0;
      frame_cnt <= '0;
      cur_speed <= '0;
      sf_write  <= 1'b0;
      sf_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      imm_pend  <= imm_pend_nxt;
      frame_cnt <= frame_cnt_nxt;
      cur_speed <= cur_speed_nxt;
      sf_write  <= sf_write_nxt;
      sf_data   <= sf_data_nxt;
      busy      <= busy_nxt;
    end
  end

  // A CPU write takes priority over any step or jump landing in the same cycle
  always_comb begin
    target_nxt    = target;
    imm_pend_nxt  = imm_pend;
    frame_cnt_nxt = frame_cnt;
    cur_speed_nxt = cur_speed;
    sf_write_nxt  = 1'b0;
    sf_data_nxt   = sf_data;
    state_nxt     = state;

    if (cpu_wr) begin
      target_nxt    = cpu_data[3:0];
      imm_pend_nxt  = cpu_data[4];
      frame_cnt_nxt = '0;
    end else begin
      case (state)
        JUMP: begin
          if (vb_edge) begin
            cur_speed_nxt = target;
            sf_data_nxt   = {4'b0, target};
            sf_write_nxt  = 1'b1;
            imm_pend_nxt  = 1'b0;
            frame_cnt_nxt = '0;
          end
        end
        RAMP: begin
          if (vb_edge) begin
            if (frame_cnt == STEP_LAST) begin
              frame_cnt_nxt = '0;
              cur_speed_nxt = (cur_speed < target) ? cur_speed + SPEED_W'(1)
                                                   : cur_speed - SPEED_W'(1);
              sf_data_nxt   = {4'b0, cur_speed_nxt};
              sf_write_nxt  = 1'b1;
            end else begin
              frame_cnt_nxt = frame_cnt + CNT_W'(1);
            end
          end
        end
        default: frame_cnt_nxt = '0;
      endcase
    end

    if (imm_pend_nxt)                    state_nxt = JUMP;
    else if (cur_speed_nxt != target_nxt) state_nxt = RAMP;
    else                                  state_nxt = IDLE;

    busy_nxt = (cur_speed_nxt != target_nxt) | imm_pend_nxt;
  end

endmodule

// File: tb/tb_starfield_speed_ctl.sv
// Randomized and directed check of starfield_speed_ctl against a frame-level model.
module tb_starfield_speed_ctl;

  localparam int unsigned STEP = 2;

  logic       clk, rst, vblank, cpu_wr;
  logic [7:0] cpu_data;
  logic       sf_write;
  logic [7:0] sf_data;
  logic [3:0] cur_speed;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int m_tgt, m_imm, m_cnt, m_spd, m_wr, m_data;
  int vh1, vh2, vh3;
  int wr_count;

  starfield_speed_ctl #(.STEP_FRAMES(STEP)) dut (
    .clk(clk), .rst(rst), .vblank(vblank), .cpu_wr(cpu_wr),
    .cpu_data(cpu_data), .sf_write(sf_write), .sf_data(sf_data),
    .cur_speed(cur_speed), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, got, got, exp, exp, $time);
  endtask

  task automatic model_reset();
    m_tgt = 0; m_imm = 0; m_cnt = 0; m_spd = 0; m_wr = 0; m_data = 0;
    vh1 = 0; vh2 = 0; vh3 = 0;
  endtask

  // One clock edge of the model: edge seen two edges after vblank first sampled high
  task automatic model_step(input int wr, input int data, input int vb);
    int edge_now;
    edge_now = (vh2 == 1 && vh3 == 0) ? 1 : 0;
    vh3 = vh2; vh2 = vh1; vh1 = vb;
    m_wr = 0;
    if (wr != 0) begin
      m_tgt = data % 16;
      m_imm = (data / 16) % 2;
      m_cnt = 0;
    end else if (edge_now != 0) begin
      if (m_imm != 0) begin
        m_spd = m_tgt; m_data = m_tgt; m_wr = 1; m_imm = 0; m_cnt = 0;
      end else if (m_spd != m_tgt) begin
        if (m_cnt == STEP - 1) begin
          m_cnt = 0;
          m_spd = (m_spd < m_tgt) ? m_spd + 1 : m_spd - 1;
          m_data = m_spd; m_wr = 1;
        end else m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("sf_write", sf_write, m_wr);
    check("sf_data", sf_data, m_data);
    check("cur_speed", cur_speed, m_spd);
    check("busy", busy, ((m_spd != m_tgt) || m_imm != 0) ? 1 : 0);
    if (sf_write) wr_count++;
  endtask

  // Drive inputs at negedge, advance one clock, compare at the next negedge
  task automatic cyc(input int wr, input int data, input int vb);
    cpu_wr   = (wr != 0);
    cpu_data = 8'(data);
    vblank   = (vb != 0);
    model_step(wr, data, vb);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse();
    cyc(0, 0, 1); cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    cpu_wr = 1'b0; vblank = 1'b0; cpu_data = 8'h00;
    #1;
    check("rst_cur_speed", cur_speed, 0);
    check("rst_busy", busy, 0);
    check("rst_sf_write", sf_write, 0);
    check("rst_sf_data", sf_data, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int vb_lvl;
    int wr;
    model_reset();
    rst = 1'b1; vblank = 1'b0; cpu_wr = 1'b0; cpu_data = 8'h00;
    wr_count = 0;
    #1;
    check("reset_sf_write", sf_write, 0);
    check("reset_sf_data", sf_data, 0);
    check("reset_cur_speed", cur_speed, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // no writes while idle
    repeat (4) pulse();
    check("idle_writes", wr_count, 0);

    // ramp up to 5
    wr_count = 0;
    cyc(1, 8'h05, 0);
    repeat (10) pulse();
    check("ramp_writes", wr_count, 5);
    check("ramp_final", cur_speed, 5);
    check("ramp_busy", busy, 0);

    // immediate jump to 10
    wr_count = 0;
    cyc(1, 8'h1A, 0);
    pulse();
    check("jump_writes", wr_count, 1);
    check("jump_data", sf_data, 8'h0A);
    check("jump_busy", busy, 0);

    // reversal: down one step, then up to 12
    cyc(1, 8'h08, 0);
    pulse(); pulse();
    check("rev_step", cur_speed, 9);
    wr_count = 0;
    cyc(1, 8'h0C, 0);
    repeat (6) pulse();
    check("rev_writes", wr_count, 3);
    check("rev_final", cur_speed, 12);

    // collision: cpu_wr lands on the cycle the edge is acted upon
    cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(1, 8'h03, 0);
    check("coll_no_write", sf_write, 0);
    wr_count = 0;
    repeat (3) cyc(0, 0, 0);
    pulse();
    check("coll_wait", wr_count, 0);
    pulse();
    check("coll_write", wr_count, 1);
    check("coll_speed", cur_speed, 11);

    // async reset mid-ramp
    cyc(1, 8'h00, 0);
    repeat (6) pulse();
    cyc(1, 8'h0F, 0);
    async_reset();
    wr_count = 0;
    repeat (4) pulse();
    check("post_rst_writes", wr_count, 0);

    // randomized traffic
    vb_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) vb_lvl = 1 - vb_lvl;
      wr = ($urandom_range(0, 39) == 0) ? 1 : 0;
      cyc(wr, int'($urandom_range(0, 255)), vb_lvl);
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
